adder_8b: RTL and testbench



---
 rtl/adder_8b.sv | 80 ++++++++
 tb/tb_adder_8b.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/adder_8b.sv
// adder_8b: registered 8-bit ripple-carry adder with carry-in, carry-out,
// signed-overflow flag and a single-cycle valid qualifier.
//
// The combinational ripple chain feeds one register stage. Results appear
// one clock after the edge that sampled in_valid = 1. When in_valid is low
// the result registers hold, and out_valid drops.

module adder_8b (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    input  logic       in_valid,
    output logic [7:0] S,
    output logic       Cout,
    output logic       V,
    output logic       out_valid
);

    // Ripple chain: carry[i] is the carry into bit i, carry[8] is the carry out of bit 7.
    logic [8:0] carry;
    logic [7:0] sum_c;
    logic       v_c;

    // Register stage: _q holds the visible outputs, _d is the next value.
    logic [7:0] s_q,         s_d;
    logic       cout_q,      cout_d;
    logic       v_q,         v_d;
    logic       out_valid_q, out_valid_d;

    // Eight full-adder cells chained bit 0 to bit 7; overflow from the top two carries.
    always_comb begin
        carry    = '0;
        sum_c    = '0;
        carry[0] = Cin;
        for (int i = 0; i < 8; i++) begin
            sum_c[i]     = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        v_c = carry[7] ^ carry[8];
    end

    // Next-state: load a new result on in_valid, otherwise hold and drop out_valid.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        s_d         = s_q;
        cout_d      = cout_q;
        v_d         = v_q;
        out_valid_d = 1'b0;
        if (in_valid) begin
            s_d         = sum_c;
            cout_d      = carry[8];
            v_d         = v_c;
            out_valid_d = 1'b1;
        end
    end

    // Output registers with synchronous reset; reset wins over a same-edge capture.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (rst) begin
            s_q         <= 8'h00;
            cout_q      <= 1'b0;
            v_q         <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            s_q         <= s_d;
            cout_q      <= cout_d;
            v_q         <= v_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign S         = s_q;
    assign Cout      = cout_q;
    assign V         = v_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder_8b.sv
// Testbench for adder_8b: directed vectors with hand-computed results, hold
// and reset behaviour, and a back-to-back stream checked against a 9-bit model.

module tb_adder_8b;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic       Cin;
    logic       in_valid;
    logic [7:0] S;
    logic       Cout;
    logic       V;
    logic       out_valid;

    int tests_run    = 0;
    int tests_failed = 0;

    adder_8b dut (
        .clk       (clk),
        .rst       (rst),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .S         (S),
        .Cout      (Cout),
        .V         (V),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    // Drive one set of inputs at a falling edge, let one rising edge pass,
    // and return at the next falling edge where outputs are stable.
    task automatic step(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic vld, input logic r);
        @(negedge clk);
        A        = a;
        B        = b;
        Cin      = cin;
        in_valid = vld;
        rst      = r;
        @(negedge clk);
    endtask

    task automatic test_reset();
        step(8'hAA, 8'h55, 1'b1, 1'b1, 1'b1);
        step(8'h12, 8'h34, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if ({S, Cout, V, out_valid} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got S=%h Cout=%b V=%b ov=%b, want all 0", S, Cout, V, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [7:0] a_t [7]  = '{8'd10, 8'd127, 8'd200, 8'hFF, 8'hFF, 8'h80, 8'h80};
        logic [7:0] b_t [7]  = '{8'd5,  8'd1,   8'd100, 8'h01, 8'hFF, 8'h80, 8'hFF};
        logic       c_t [7]  = '{1'b0,  1'b0,   1'b1,   1'b0,  1'b1,  1'b0,  1'b0};
        logic [7:0] s_t [7]  = '{8'h0F, 8'h80,  8'h2D,  8'h00, 8'hFF, 8'h00, 8'h7F};
        logic       co_t [7] = '{1'b0,  1'b0,   1'b1,   1'b1,  1'b1,  1'b1,  1'b1};
        logic       v_t [7]  = '{1'b0,  1'b1,   1'b0,   1'b0,  1'b0,  1'b1,  1'b1};
        for (int i = 0; i < 7; i++) begin
            step(a_t[i], b_t[i], c_t[i], 1'b1, 1'b0);
            tests_run++;
            if ({S, Cout, V, out_valid} !== {s_t[i], co_t[i], v_t[i], 1'b1}) begin
                tests_failed++;
                $display("FAIL directed_%0d: A=%h B=%h Cin=%b got S=%h Cout=%b V=%b ov=%b, want S=%h Cout=%b V=%b ov=1",
                         i, a_t[i], b_t[i], c_t[i], S, Cout, V, out_valid, s_t[i], co_t[i], v_t[i]);
            end
        end
    endtask

    task automatic test_hold();
        step(8'd127, 8'd1, 1'b0, 1'b1, 1'b0);
        step(8'h01, 8'h01, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({S, Cout, V, out_valid} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL hold_1: got S=%h Cout=%b V=%b ov=%b, want S=80 Cout=0 V=1 ov=0", S, Cout, V, out_valid);
        end
        step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        tests_run++;
        if ({S, Cout, V, out_valid} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL hold_2: got S=%h Cout=%b V=%b ov=%b, want S=80 Cout=0 V=1 ov=0", S, Cout, V, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        step(8'd200, 8'd100, 1'b1, 1'b1, 1'b0);
        step(8'h7F, 8'h01, 1'b0, 1'b1, 1'b1);
        tests_run++;
        if ({S, Cout, V, out_valid} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_mid: got S=%h Cout=%b V=%b ov=%b, want all 0", S, Cout, V, out_valid);
        end
        step(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);
        tests_run++;
        if ({S, Cout, V, out_valid} !== 11'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got S=%h Cout=%b V=%b ov=%b, want all 0", S, Cout, V, out_valid);
        end
        step(8'd10, 8'd5, 1'b0, 1'b1, 1'b0);
        tests_run++;
        if ({S, Cout, V, out_valid} !== {8'h0F, 1'b0, 1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL reset_first_result: got S=%h Cout=%b V=%b ov=%b, want S=0F Cout=0 V=0 ov=1", S, Cout, V, out_valid);
        end
    endtask

    // Stream one vector per clock; each falling edge checks the previous vector.
    task automatic test_back_to_back();
        logic [7:0] exp_s;
        logic       exp_c;
        logic       exp_v;
        logic [8:0] raw;
        logic [7:0] a, b;
        logic       c;
        int         n = 0;
        for (int ai = 0; ai < 256; ai++) begin
            for (int bi = 0; bi < 32; bi++) begin
                a = ai[7:0];
                b = 8'(bi * 8 + ((ai + bi) % 8));
                c = 1'(ai + bi);
                @(negedge clk);
                if (n > 0) begin
                    tests_run++;
                    if ({S, Cout, V, out_valid} !== {exp_s, exp_c, exp_v, 1'b1}) begin
                        tests_failed++;
                        $display("FAIL stream_%0d: got S=%h Cout=%b V=%b ov=%b, want S=%h Cout=%b V=%b ov=1",
                                 n, S, Cout, V, out_valid, exp_s, exp_c, exp_v);
                    end
                end
                A        = a;
                B        = b;
                Cin      = c;
                in_valid = 1'b1;
                rst      = 1'b0;
                raw      = {1'b0, a} + {1'b0, b} + {8'b0, c};
                exp_s    = raw[7:0];
                exp_c    = raw[8];
                exp_v    = (a[7] == b[7]) && (raw[7] != a[7]);
                n++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        tests_run++;
        if ({S, Cout, V, out_valid} !== {exp_s, exp_c, exp_v, 1'b1}) begin
            tests_failed++;
            $display("FAIL stream_last: got S=%h Cout=%b V=%b ov=%b, want S=%h Cout=%b V=%b ov=1",
                     S, Cout, V, out_valid, exp_s, exp_c, exp_v);
        end
        @(negedge clk);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_end_valid: got ov=%b, want 0", out_valid);
        end
    endtask

    initial begin
        rst      = 1'b1;
        A        = 8'h00;
        B        = 8'h00;
        Cin      = 1'b0;
        in_valid = 1'b0;
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
